// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter unit.
package pc_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  typedef enum logic [2:0] {
    SRC_TRAP, SRC_TRET, SRC_REDIR, SRC_RAS, SRC_SEQ, SRC_HOLD
  } src_e;

  localparam int ADDR_MAX = 64;

  // Clears the sub-instruction offset bits; ib must be a power of two.
  function automatic logic [ADDR_MAX-1:0] align_addr(input logic [ADDR_MAX-1:0] a,
                                                     input int unsigned ib);
    return a & ~(ADDR_MAX'(ib) - ADDR_MAX'(1));
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-side and control-side signals of the PC unit.
interface pc_if #(parameter int XLEN = 32);
  logic            pc_ready;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            trap;
  logic [XLEN-1:0] trap_pc;
  logic            trap_return;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            call;
  logic            ret;
  logic [XLEN-1:0] ret_target;
  logic [XLEN-1:0] epc;
  logic            ras_empty;

  modport master (
    output pc_ready, trap, trap_pc, trap_return, redirect, redirect_target,
           call, ret, ret_target,
    input  pc, pc_valid, epc, ras_empty
  );

  modport slave (
    input  pc_ready, trap, trap_pc, trap_return, redirect, redirect_target,
           call, ret, ret_target,
    output pc, pc_valid, epc, ras_empty
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  output logic [XLEN-1:0] top,
  output logic            empty
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW:0]     cnt_q, cnt_d;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PW'(1);
      if (cnt_q != FULL) cnt_d = cnt_q + (PW+1)'(1);
    end else if (pop && cnt_q != '0) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: a zero count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_d] <= push_data;
  end

  assign top   = mem_q[ptr_q];
  assign empty = (cnt_q == '0);
endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with prioritised next-PC select, EPC, RAS and bubble FSM.
module pc_unit import pc_pkg::*; #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int unsigned     INSTR_BYTES  = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input logic clk,
  input logic reset,
  pc_if.slave bus
);
  state_e          state_q, state_d;
  src_e            src;
  logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d, ras_top;
  logic            ras_empty, push, pop, evt, pc_valid;

  function automatic logic [XLEN-1:0] al(input logic [XLEN-1:0] a);
    return XLEN'(align_addr(ADDR_MAX'(a), INSTR_BYTES));
  endfunction

  assign pc_valid = (state_q == RUN);

  always_comb begin
    if      (bus.trap)                  src = SRC_TRAP;
    else if (bus.trap_return)           src = SRC_TRET;
    else if (bus.redirect)              src = SRC_REDIR;
    else if (bus.ret)                   src = SRC_RAS;
    else if (pc_valid && bus.pc_ready)  src = SRC_SEQ;
    else                                src = SRC_HOLD;
    evt = (src != SRC_SEQ) && (src != SRC_HOLD);
  end

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    push  = 1'b0;
    pop   = 1'b0;
    case (src)
      SRC_TRAP:  begin pc_d = TRAP_VECTOR; epc_d = bus.trap_pc; end
      SRC_TRET:  pc_d = al(epc_q);
      SRC_REDIR: begin pc_d = al(bus.redirect_target); push = bus.call; end
      SRC_RAS: begin
        if (ras_empty) pc_d = al(bus.ret_target);
        else begin pc_d = al(ras_top); pop = 1'b1; end
      end
      SRC_SEQ:   pc_d = pc_q + XLEN'(INSTR_BYTES);
      default:   ;
    endcase
  end

  // Any redirect-class event costs exactly one bubble, whatever the current state.
  always_comb begin
    state_d = state_q;
    if (evt) state_d = FLUSH;
    else if (state_q != RUN) state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
    end
  end

  pc_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk), .reset(reset), .push(push), .push_data(pc_q + XLEN'(INSTR_BYTES)),
    .pop(pop), .top(ras_top), .empty(ras_empty)
  );

  assign bus.pc        = pc_q;
  assign bus.pc_valid  = pc_valid;
  assign bus.epc       = epc_q;
  assign bus.ras_empty = ras_empty;
endmodule

// File: tb/tb_pc_unit.sv
// Scoreboarded random + directed bench for pc_unit against a queue-based model.
module tb_pc_unit;
  localparam int          XL    = 32;
  localparam logic [31:0] RV    = 32'h0;
  localparam logic [31:0] TV    = 32'h100;
  localparam int          IB    = 4;
  localparam int          DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] epc;
    logic        empty;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_if #(.XLEN(XL)) bus();

  pc_unit #(.XLEN(XL), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .INSTR_BYTES(IB),
            .RAS_DEPTH(DEPTH)) dut (.clk(clk), .reset(rst), .bus(bus));

  exp_t        sb[$];
  logic [31:0] m_ras[$];
  logic [31:0] m_pc, m_epc;
  logic        m_valid;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] al(input logic [31:0] a);
    return a & ~32'(IB - 1);
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc", bus.pc, e.pc);
      chk("pc_valid", 32'(bus.pc_valid), 32'(e.valid));
      chk("epc", bus.epc, e.epc);
      chk("ras_empty", 32'(bus.ras_empty), 32'(e.empty));
    end
  end

  task automatic clr();
    bus.trap = 0; bus.trap_return = 0; bus.redirect = 0; bus.call = 0; bus.ret = 0;
  endtask

  // Apply the current inputs for one edge, predicting the architectural result.
  task automatic tick();
    logic evt;
    if (!rst) begin
      m_pc = RV; m_valid = 0; m_epc = 0; m_ras.delete();
    end else begin
      evt = bus.trap | bus.trap_return | bus.redirect | bus.ret;
      if (bus.trap) begin
        m_pc = TV; m_epc = bus.trap_pc;
      end else if (bus.trap_return) begin
        m_pc = al(m_epc);
      end else if (bus.redirect) begin
        if (bus.call) begin
          m_ras.push_back(m_pc + IB);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
        m_pc = al(bus.redirect_target);
      end else if (bus.ret) begin
        if (m_ras.size() > 0) m_pc = al(m_ras.pop_back());
        else m_pc = al(bus.ret_target);
      end else if (m_valid && bus.pc_ready) begin
        m_pc = m_pc + IB;
      end
      m_valid = !evt;
    end
    sb.push_back('{pc: m_pc, valid: m_valid, epc: m_epc, empty: (m_ras.size() == 0)});
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] t, input logic c);
    clr(); bus.redirect = 1; bus.redirect_target = t; bus.call = c; tick();
    clr(); tick();
  endtask

  initial begin
    rst = 0; clr(); bus.pc_ready = 1;
    bus.trap_pc = 0; bus.redirect_target = 0; bus.ret_target = 0;
    tick(); tick();
    rst = 1;
    repeat (5) tick();
    bus.pc_ready = 0;
    repeat (3) tick();

    // call/return round trip from pc 'h40
    redir(32'h40, 0);
    redir(32'h200, 1);
    repeat (2) tick();
    clr(); bus.ret = 1; bus.ret_target = 32'h900; tick();
    clr(); repeat (2) tick();

    // overflow the stack, then drain one past empty
    for (int i = 0; i < 5; i++) redir(32'h1000 + 32'(i) * 32'h100, 1);
    for (int i = 0; i < 5; i++) begin
      clr(); bus.ret = 1; bus.ret_target = 32'h900; tick();
      clr(); tick();
    end

    // trap wins over redirect, call and ret in the same cycle
    redir(32'h3000, 1);
    clr(); bus.trap = 1; bus.trap_pc = 32'h1234; bus.redirect = 1; bus.call = 1;
    bus.redirect_target = 32'h500; bus.ret = 1; tick();
    clr(); tick();
    bus.trap_return = 1; tick();
    clr(); tick();

    // address wrap, target alignment, reset during the bubble
    bus.pc_ready = 1;
    redir(32'hFFFF_FFFC, 0);
    tick();
    clr(); bus.redirect = 1; bus.redirect_target = 32'h203; tick();
    clr(); rst = 0; tick();
    rst = 1; repeat (3) tick();

    for (int i = 0; i < 600; i++) begin
      clr();
      rst = ($urandom_range(0, 99) != 0);
      bus.pc_ready = $urandom_range(0, 3) != 0;
      bus.trap = $urandom_range(0, 15) == 0;
      bus.trap_return = $urandom_range(0, 11) == 0;
      bus.redirect = $urandom_range(0, 5) == 0;
      bus.call = $urandom_range(0, 1) == 1;
      bus.ret = $urandom_range(0, 6) == 0;
      bus.trap_pc = $urandom();
      bus.redirect_target = $urandom();
      bus.ret_target = $urandom();
      tick();
    end

    clr(); tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
